// File: rtl/dpsram_arb_pkg.sv
// Shared types and widths for the DPSRAM port-A arbiter.
package dpsram_arb_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic {ARB, LOCKED} arb_state_e;

  // Index of the set bit in a one-hot vector (up to 8 requesters); 0 when empty.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/dpsram_port_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic          valid
);
  logic [2*N-1:0] dbl, back;
  logic [N-1:0]   rot, first;

  // Rotate so ptr lands at bit 0, pick the lowest set bit, rotate back.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  // Lowest set bit of the rotated request vector.
  always_comb begin
    first = '0;
    for (int k = 0; k < N; k++)
      if (rot[k] && first == '0) first[k] = 1'b1;
  end

  assign back   = {first, first} << ptr;
  assign win_oh = back[2*N-1:N];
  assign valid  = |req;
endmodule

// File: rtl/dpsram_port_arbiter.sv
// Round-robin arbiter with burst lock sharing DPSRAM port A among NREQ requesters.
// Optional build macro ARB_STATS_EN adds a saturating conflict_count output.
module dpsram_port_arbiter
  import dpsram_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              lock,
  input  logic [NREQ-1:0][ADDR_W-1:0]  addr,
  input  logic [NREQ-1:0]              we,
  input  logic [NREQ-1:0][DATA_W-1:0]  wdata,
  output logic [NREQ-1:0]              gnt,
  output logic [DATA_W-1:0]            rdata,
  output logic [NREQ-1:0]              rvalid,
  output logic                         port_A_clk,
  output logic [ADDR_W-1:0]            port_A_addr,
  output logic                         port_A_we,
  output logic [DATA_W-1:0]            port_A_data_in,
  input  logic [DATA_W-1:0]            port_A_data_out
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]                  conflict_count
`endif
);
  localparam int IW = $clog2(NREQ);
  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  arb_state_e      state_q;
  logic [IW-1:0]   rr_q, owner_q, last_q, win_idx, sel;
  logic [7:0]      burst_q;
  logic [NREQ-1:0] owner_oh, pick_req, pick_oh;
  logic            pick_vld, owner_ok, others, at_max, forced, hold, accept;

  assign port_A_clk = clk;

  // Owner keeps the port while locked, unless the burst is spent and someone waits.
  assign owner_oh = NREQ'(1) << owner_q;
  assign owner_ok = (state_q == LOCKED) && req[owner_q] && lock[owner_q];
  assign others   = |(req & ~owner_oh);
  assign at_max   = burst_q >= MAXB;
  assign forced   = owner_ok && at_max && others;
  assign hold     = owner_ok && !forced;
  assign pick_req = forced ? (req & ~owner_oh) : req;

  rr_pick #(.N(NREQ)) u_pick (
    .req    (pick_req),
    .ptr    (rr_q),
    .win_oh (pick_oh),
    .valid  (pick_vld)
  );

  // Grant is held off entirely while reset is asserted.
  always_comb begin
    gnt = '0;
    if (!nreset) gnt = hold ? owner_oh : pick_oh;
  end

  assign accept  = |gnt;
  assign win_idx = IW'(onehot_to_idx(8'(gnt)));
  // Idle cycles keep the last owner's slice on the bus so addr/data do not toggle.
  assign sel            = accept ? win_idx : last_q;
  assign port_A_addr    = nreset ? '0 : addr[sel];
  assign port_A_data_in = nreset ? '0 : wdata[sel];
  assign port_A_we      = accept & we[win_idx];

  // Arbitration state, burst accounting and read-return pipe.
  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q <= ARB;
      rr_q    <= '0;
      owner_q <= '0;
      last_q  <= '0;
      burst_q <= '0;
      rdata   <= '0;
      rvalid  <= '0;
    end else begin
      rdata  <= port_A_data_out;
      rvalid <= gnt & ~we;
      if (accept) begin
        last_q <= win_idx;
        rr_q   <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end
      if (hold) begin
        if (!at_max) burst_q <= burst_q + 8'd1;
      end else if (accept && !forced && lock[win_idx]) begin
        state_q <= LOCKED;
        owner_q <= win_idx;
        burst_q <= 8'd1;
      end else begin
        state_q <= ARB;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic multi;
  assign multi = (req & (req - NREQ'(1))) != '0;

  // Saturating count of cycles with more than one requester active.
  always_ff @(posedge clk) begin
    if (nreset)                             conflict_count <= '0;
    else if (multi && conflict_count != 16'hFFFF) conflict_count <= conflict_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dpsram_port_arbiter.sv
// Bench for dpsram_port_arbiter: directed table, hand sequences, random vs. reference model.
module tb_dpsram_port_arbiter;
  localparam int N  = 2;
  localparam int MB = 4;

  logic                 clk = 1'b0;
  logic                 nreset;
  logic [N-1:0]         req, lock, we, gnt, rvalid;
  logic [N-1:0][15:0]   addr;
  logic [N-1:0][31:0]   wdata;
  logic [31:0]          rdata, port_A_data_in, port_A_data_out;
  logic                 port_A_clk, port_A_we;
  logic [15:0]          port_A_addr;
`ifdef ARB_STATS_EN
  logic [15:0]          conflict_count;
`endif

  always #5 clk = ~clk;

  dpsram_port_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .nreset(nreset), .req(req), .lock(lock), .addr(addr), .we(we),
    .wdata(wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
    .port_A_clk(port_A_clk), .port_A_addr(port_A_addr), .port_A_we(port_A_we),
    .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out)
`ifdef ARB_STATS_EN
    , .conflict_count(conflict_count)
`endif
  );

  // SRAM stand-in: read data is captured by the arbiter on the acceptance edge.
  logic [31:0] sram [256];
  assign port_A_data_out = sram[port_A_addr[7:0]];
  always @(posedge clk) if (port_A_we) sram[port_A_addr[7:0]] <= port_A_data_in;

  // Reference model state
  int          m_rr, m_owner, m_burst, m_last;
  bit          m_locked;
  logic [31:0] ref_mem [256];
  logic [N-1:0] exp_rv;
  logic [31:0] exp_rd;
  int unsigned exp_cc;
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    m_rr = 0; m_owner = 0; m_burst = 0; m_last = 0; m_locked = 0; exp_cc = 0;
  endtask

  // One cycle: drive, check combinational outputs, advance, check read return.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] w,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      output logic [N-1:0] g_obs);
    int g, ex, j;
    bit others, forced, holding;
    logic [N-1:0] eg;
    logic [0:0] si;
    logic [15:0] ea;
    req = r; lock = l; we = w;
    addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1;
    #1;
    g = -1; ex = -1; forced = 0; holding = 0;
    if (m_locked && r[m_owner] && l[m_owner]) begin
      others = 0;
      for (int k = 0; k < N; k++) if (k != m_owner && r[k]) others = 1;
      if (m_burst < MB || !others) begin g = m_owner; holding = 1; end
      else begin ex = m_owner; forced = 1; end
    end
    if (g < 0)
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (g < 0 && r[j] && j != ex) g = j;
      end
    eg = (g >= 0) ? (N'(1) << g) : '0;
    si = 1'((g >= 0) ? g : m_last);
    ea = addr[si];
    g_obs = gnt;
    chk("gnt", gnt, eg);
    chk("port_we", port_A_we, (g >= 0) && w[si]);
    chk("port_addr", port_A_addr, ea);
    if (g >= 0 && w[si]) chk("port_wdata", port_A_data_in, wdata[si]);
    exp_rv = (g >= 0 && !w[si]) ? eg : '0;
    exp_rd = ref_mem[ea[7:0]];
    if (g >= 0 && w[si]) ref_mem[ea[7:0]] = wdata[si];
    if (g >= 0) begin m_rr = (g + 1) % N; m_last = g; end
    if (holding) m_burst = (m_burst < MB) ? m_burst + 1 : MB;
    else if (g >= 0 && !forced && l[si]) begin m_locked = 1; m_owner = g; m_burst = 1; end
    else m_locked = 0;
    if (r == 2'b11 && exp_cc < 65535) exp_cc++;
    @(posedge clk); @(negedge clk);
    chk("rvalid", rvalid, exp_rv);
    if (exp_rv != '0) chk("rdata", rdata, exp_rd);
`ifdef ARB_STATS_EN
    chk("conflict_count", conflict_count, exp_cc);
`endif
  endtask

  task automatic do_reset(input logic [N-1:0] r, input logic [N-1:0] l);
    nreset = 1'b1; req = r; lock = l; we = '0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_we", port_A_we, 0);
    chk("rst_addr", port_A_addr, 0);
    @(posedge clk); @(negedge clk);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
`ifdef ARB_STATS_EN
    chk("rst_conflict_count", conflict_count, 0);
`endif
    model_clear();
    nreset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] r, l, w, g;
  } vec_t;
  vec_t tbl [17];

  initial begin
    logic [N-1:0] gobs;
    for (int i = 0; i < 256; i++) begin
      sram[i]    <= {16'hA5A5, 8'h00, 8'(i)};
      ref_mem[i]  = {16'hA5A5, 8'h00, 8'(i)};
    end
    sram[8'h10]    <= 32'hDEADBEEF;
    ref_mem[8'h10]  = 32'hDEADBEEF;
    nreset = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    model_clear();

    //   req    lock   we     gnt
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 2'b01};
    tbl[1]  = '{2'b11, 2'b00, 2'b00, 2'b10};
    tbl[2]  = '{2'b11, 2'b00, 2'b00, 2'b01};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 2'b10};
    tbl[4]  = '{2'b11, 2'b01, 2'b00, 2'b01};
    tbl[5]  = '{2'b11, 2'b01, 2'b00, 2'b01};
    tbl[6]  = '{2'b11, 2'b01, 2'b00, 2'b01};
    tbl[7]  = '{2'b11, 2'b01, 2'b00, 2'b01};
    tbl[8]  = '{2'b11, 2'b01, 2'b00, 2'b10};
    tbl[9]  = '{2'b11, 2'b01, 2'b00, 2'b01};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{2'b01, 2'b01, 2'b00, 2'b01};
    tbl[12] = '{2'b01, 2'b01, 2'b00, 2'b01};
    tbl[13] = '{2'b11, 2'b00, 2'b00, 2'b10};
    tbl[14] = '{2'b10, 2'b01, 2'b00, 2'b10};
    tbl[15] = '{2'b11, 2'b00, 2'b00, 2'b01};
    tbl[16] = '{2'b11, 2'b00, 2'b00, 2'b10};

    @(negedge clk);
    do_reset(2'b00, 2'b00);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].l, tbl[i].w, 16'h0010, 16'h0020, 32'h0, 32'h0, gobs);
      chk($sformatf("tbl_gnt[%0d]", i), gobs, tbl[i].g);
    end

    // Single read from requester 0
    step(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0020, 32'h0, 32'h0, gobs);
    chk("read_rvalid", rvalid, 2'b01);
    chk("read_rdata", rdata, 32'hDEADBEEF);

    // Write by requester 1, then read-back by requester 0
    step(2'b10, 2'b00, 2'b10, 16'h0010, 16'h0020, 32'h0, 32'h12345678, gobs);
    chk("wr_no_rvalid", rvalid, 2'b00);
    step(2'b01, 2'b00, 2'b00, 16'h0020, 16'h0020, 32'h0, 32'h0, gobs);
    chk("rbw_rvalid", rvalid, 2'b01);
    chk("rbw_rdata", rdata, 32'h12345678);

    // Reset in the middle of a locked read burst
    step(2'b01, 2'b01, 2'b00, 16'h0011, 16'h0020, 32'h0, 32'h0, gobs);
    step(2'b11, 2'b01, 2'b00, 16'h0012, 16'h0020, 32'h0, 32'h0, gobs);
    do_reset(2'b11, 2'b01);
    step(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 32'h0, 32'h0, gobs);
    chk("post_rst_gnt", gobs, 2'b01);

    // Random traffic; only requester 0 ever asks for lock
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 59) == 0)
        do_reset(2'($urandom), 2'($urandom));
      else
        step(2'($urandom), {1'b0, 1'($urandom_range(0, 3) != 0)}, 2'($urandom),
             16'($urandom), 16'($urandom), $urandom, $urandom, gobs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
